// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 buffered demultiplexer.
package demux_pkg;

  localparam int NUM_CH        = 4;
  localparam int SEL_W         = 2;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  // One-hot decode of a channel select.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_buf_chan_fifo.sv
// Single-channel FIFO: push to tail, pop from head, head word shown combinationally.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // When empty, show the slot just behind the read pointer: that is the
  // word most recently popped, so the output holds its last head value.
  assign last_ptr = rd_ptr - 1'b1;
  assign head     = empty ? mem[last_ptr] : mem[rd_ptr];

  // Storage: cleared by reset so the data output reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer advance, wrapping modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy 0..DEPTH; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux1to4_buf.sv
// 1-to-4 demultiplexer with a small FIFO per output channel.
// The top level only decodes the push, muxes in_ready and concatenates outputs.
module demux1to4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH-1:0]       full
);

  logic [NUM_CH-1:0] push_vec;
  logic [NUM_CH-1:0] empty_vec;

  // Ready depends only on the selected channel's registered occupancy.
  assign in_ready  = !full[in_sel];
  assign push_vec  = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;
  assign out_valid = ~empty_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_vec[i]),
      .push_data (in_data),
      .pop       (out_ready[i]),
      .full      (full[i]),
      .empty     (empty_vec[i]),
      .head      (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: per-channel queue model, driver pushes expectations,
// monitor compares outputs every cycle and retires words as they are consumed.
module tb_demux1to4_buf;
  import demux_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH-1:0]       full;

  demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] q [NUM_CH][$];
  int               checks = 0;
  int               failures = 0;
  int               accepted = 0;
  bit               pend = 1'b0;
  logic [SEL_W-1:0] pend_sel;
  logic [WIDTH-1:0] pend_data;
  logic [NUM_CH-1:0] mon_pops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready(input int ch);
    return q[ch].size() < DEPTH;
  endfunction

  // One clock of stimulus: commit the word accepted at this edge, then drive the next inputs.
  task automatic step(input bit v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                      input logic [NUM_CH-1:0] ordy);
    @(posedge clk);
    if (pend) begin
      q[pend_sel].push_back(pend_data);
      pend = 1'b0;
    end
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    if (v && rst_n && model_ready(int'(s))) begin
      pend      = 1'b1;
      pend_sel  = s;
      pend_data = d;
      accepted++;
    end
  endtask

  // Monitor: compare at the falling edge, retire consumed words at the next rising edge.
  always begin
    @(negedge clk);
    mon_pops = '0;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(model_ready(int'(in_sel))));
      for (int i = 0; i < NUM_CH; i++) begin
        chk($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(q[i].size() != 0));
        chk($sformatf("full%0d", i), 32'(full[i]), 32'(q[i].size() == DEPTH));
        if (out_valid[i] && q[i].size() != 0) begin
          chk($sformatf("head%0d", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(q[i][0]));
          if (out_ready[i]) mon_pops[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mon_pops[i]) void'(q[i].pop_front());
      end
    end
  end

  initial begin
    int cyc;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word to ch2, then consume it.
    step(1'b1, 2'd2, 8'hA5, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("a5_valid", 32'(out_valid), 32'b0100);
    chk("a5_data", 32'(out_data[23:16]), 32'hA5);
    step(1'b0, 2'd0, 8'h00, 4'b0100);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("a5_popped", 32'(out_valid), 32'b0000);

    // Fill ch1.
    step(1'b1, 2'd1, 8'h11, 4'b0000);
    step(1'b1, 2'd1, 8'h22, 4'b0000);
    step(1'b0, 2'd1, 8'h00, 4'b0000);
    @(negedge clk);
    chk("ch1_full", 32'(full[1]), 32'h1);
    chk("ch1_sel_ready", 32'(in_ready), 32'h0);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("ch0_sel_ready", 32'(in_ready), 32'h1);

    // Push into full ch1 while it pops: push refused, 0x11 leaves.
    step(1'b1, 2'd1, 8'h99, 4'b0010);
    step(1'b0, 2'd1, 8'h00, 4'b0000);
    @(negedge clk);
    chk("full_pop_ready", 32'(in_ready), 32'h1);
    chk("full_pop_valid", 32'(out_valid[1]), 32'h1);
    chk("full_pop_full", 32'(full[1]), 32'h0);
    chk("full_pop_head", 32'(out_data[15:8]), 32'h22);
    step(1'b0, 2'd0, 8'h00, 4'b0010);

    // ch3 with one word: simultaneous push and pop.
    step(1'b1, 2'd3, 8'h44, 4'b0000);
    step(1'b1, 2'd3, 8'h33, 4'b1000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("pp_valid", 32'(out_valid[3]), 32'h1);
    chk("pp_full", 32'(full[3]), 32'h0);
    chk("pp_head", 32'(out_data[31:24]), 32'h33);
    step(1'b0, 2'd0, 8'h00, 4'b1000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);

    // Random traffic until 1000 words are accepted.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      step($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 3)), WIDTH'($urandom),
           NUM_CH'($urandom));
      cyc++;
    end
    chk("random_accepted", 32'(accepted), 32'd1000);
    repeat (2 * DEPTH + 2) step(1'b0, 2'd0, 8'h00, 4'b1111);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("drained_valid", 32'(out_valid), 32'h0);

    // Reset mid-stream with ch0 and ch2 holding words.
    step(1'b1, 2'd0, 8'h5C, 4'b0000);
    step(1'b1, 2'd2, 8'h6D, 4'b0000);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'b0101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NUM_CH; i++) q[i].delete();
    pend = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_full", 32'(full), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h5A;
    out_ready = '0;
    pend      = 1'b1;
    pend_sel  = 2'd0;
    pend_data = 8'h5A;
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'b0001);
    chk("post_rst_data", 32'(out_data[7:0]), 32'h5A);
    step(1'b0, 2'd0, 8'h00, 4'b0001);
    step(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
